// File: rtl/mem_pkg.sv
// Shared types and constants for the data memory controller and its storage array.
package mem_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } state_e;

  localparam int unsigned DefDataW = 64;
  localparam int unsigned DefDepth = 16384;

  // Latency counter width: enough to hold LATENCY-1, never narrower than one bit.
  function automatic int unsigned cnt_width(int unsigned latency);
    return (latency <= 2) ? 1 : $clog2(latency);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word storage: synchronous byte-masked write, synchronous registered read.
module mem_array
  import mem_pkg::*;
#(
  parameter int unsigned DataW    = DefDataW,
  parameter int unsigned Depth    = DefDepth,
  parameter int unsigned AddrW    = (Depth > 1) ? $clog2(Depth) : 1,
  parameter int unsigned NumBytes = DataW / 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                we_i,
  input  logic                re_i,
  input  logic [AddrW-1:0]    addr_i,
  input  logic [DataW-1:0]    wdata_i,
  input  logic [NumBytes-1:0] be_i,
  output logic [DataW-1:0]    rdata_o
);

  logic [DataW-1:0] mem_q [Depth];
  logic [DataW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < NumBytes; i++) begin
        if (be_i[i]) begin
          mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  // Read register doubles as the controller's read_data: holds until the next read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Word-addressed data memory with request/done handshake, configurable latency,
// per-byte write enables and a sticky error flag for malformed requests.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DEPTH   = DefDepth,
  parameter int unsigned LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  read_en,
  input  logic                  write_en,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W-1:0]     write_data,
  input  logic [DATA_W/8-1:0]   byte_en,
  output logic [DATA_W-1:0]     read_data,
  output logic                  busy,
  output logic                  done,
  output logic                  dmem_error
);

  localparam int unsigned NumBytes = DATA_W / 8;
  localparam int unsigned CntW     = cnt_width(LATENCY);
  localparam int unsigned MemAw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Compare wide enough for both the full address and DEPTH so nothing is truncated.
  localparam int unsigned CmpW     = (ADDR_W >= 32) ? ADDR_W + 1 : 33;
  localparam logic [CntW-1:0] CntLoad = CntW'(LATENCY - 1);

  state_e                state_q;
  logic [CntW-1:0]       cnt_q;
  logic                  op_write_q;
  logic [MemAw-1:0]      addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [NumBytes-1:0]   be_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;

  logic addr_ok;
  logic req_valid;
  logic req_bad;
  logic access;
  logic mem_we;
  logic mem_re;

  assign addr_ok   = CmpW'(address) < CmpW'(DEPTH);
  assign req_valid = (read_en ^ write_en) & addr_ok;
  assign req_bad   = (read_en & write_en) | ((read_en | write_en) & ~addr_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            state_q    <= StBusy;
            busy_q     <= 1'b1;
            cnt_q      <= CntLoad;
            op_write_q <= write_en;
            addr_q     <= MemAw'(address);
            wdata_q    <= write_data;
            be_q       <= byte_en;
          end else if (req_bad) begin
            err_q <= 1'b1;
          end
        end
        StBusy: begin
          // Enables seen here are deliberately ignored: no error, no queueing.
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntW'(1);
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // The array access happens on the same edge that raises done.
  assign access = (state_q == StBusy) && (cnt_q == '0);
  assign mem_we = access & op_write_q;
  assign mem_re = access & ~op_write_q;

  mem_array #(
    .DataW    (DATA_W),
    .Depth    (DEPTH),
    .AddrW    (MemAw),
    .NumBytes (NumBytes)
  ) u_mem_array (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .addr_i  (addr_q),
    .wdata_i (wdata_q),
    .be_i    (be_q),
    .rdata_o (read_data)
  );

  assign busy       = busy_q;
  assign done       = done_q;
  assign dmem_error = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: two instances (LATENCY 1 and 4) against a word-map reference model.
module tb_data_mem_ctrl;

  localparam int unsigned Depth = 16384;

  logic        clk = 1'b0;
  logic        rst_n [2];
  logic        re    [2];
  logic        we    [2];
  logic [63:0] addr  [2];
  logic [63:0] wdata [2];
  logic [7:0]  be    [2];
  logic [63:0] rdata [2];
  logic        busy  [2];
  logic        done  [2];
  logic        err   [2];

  int          lat_of  [2] = '{1, 4};
  bit          err_exp [2];
  logic [63:0] rd_exp  [2];
  logic [63:0] mdl [longint];
  longint      pool [$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DATA_W(64), .ADDR_W(64), .DEPTH(Depth), .LATENCY(1)) u_dut_l1 (
    .clk        (clk),
    .rst_n      (rst_n[0]),
    .read_en    (re[0]),
    .write_en   (we[0]),
    .address    (addr[0]),
    .write_data (wdata[0]),
    .byte_en    (be[0]),
    .read_data  (rdata[0]),
    .busy       (busy[0]),
    .done       (done[0]),
    .dmem_error (err[0])
  );

  data_mem_ctrl #(.DATA_W(64), .ADDR_W(64), .DEPTH(Depth), .LATENCY(4)) u_dut_l4 (
    .clk        (clk),
    .rst_n      (rst_n[1]),
    .read_en    (re[1]),
    .write_en   (we[1]),
    .address    (addr[1]),
    .write_data (wdata[1]),
    .byte_en    (be[1]),
    .read_data  (rdata[1]),
    .busy       (busy[1]),
    .done       (done[1]),
    .dmem_error (err[1])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic longint key(input int k, input logic [63:0] a);
    return (longint'(k) << 32) | longint'(a[31:0]);
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                        input logic [7:0] m);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++) if (m[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  // Valid request: checks busy for LATENCY cycles, then a single done cycle.
  task automatic req(input int k, input bit w, input logic [63:0] a, input logic [63:0] d,
                     input logic [7:0] m, input bit tog);
    longint kk;
    kk = key(k, a);
    @(negedge clk);
    re[k] = !w; we[k] = w; addr[k] = a; wdata[k] = d; be[k] = m;
    @(posedge clk); #1;
    re[k] = 1'b0; we[k] = 1'b0;
    if (w) mdl[kk] = merge(mdl.exists(kk) ? mdl[kk] : 64'h0, d, m);
    else   rd_exp[k] = mdl[kk];
    check("busy_after_accept", 64'(busy[k]), 64'd1);
    check("done_after_accept", 64'(done[k]), 64'd0);
    for (int i = 1; i <= lat_of[k]; i++) begin
      // Scramble inputs while busy: the latched request must be used.
      addr[k] = {$urandom, $urandom}; wdata[k] = {$urandom, $urandom}; be[k] = 8'($urandom);
      if (tog) we[k] = ~we[k];
      @(posedge clk); #1;
      if (i < lat_of[k]) begin
        check("busy_inflight", 64'(busy[k]), 64'd1);
        check("done_inflight", 64'(done[k]), 64'd0);
      end else begin
        re[k] = 1'b0; we[k] = 1'b0;
        check("done_pulse", 64'(done[k]), 64'd1);
        check("busy_at_done", 64'(busy[k]), 64'd0);
        check(w ? "rdata_hold" : "rdata", rdata[k], rd_exp[k]);
      end
    end
    check("err_flag", 64'(err[k]), 64'(err_exp[k]));
  endtask

  // Malformed request: sets the sticky flag, never starts an access.
  task automatic rej(input int k, input bit r, input bit w, input logic [63:0] a);
    @(negedge clk);
    re[k] = r; we[k] = w; addr[k] = a; wdata[k] = 64'hDEAD_BEEF; be[k] = 8'hFF;
    @(posedge clk); #1;
    re[k] = 1'b0; we[k] = 1'b0;
    err_exp[k] = 1'b1;
    check("rej_busy", 64'(busy[k]), 64'd0);
    check("rej_done", 64'(done[k]), 64'd0);
    check("rej_err", 64'(err[k]), 64'd1);
    @(posedge clk); #1;
    check("rej_busy2", 64'(busy[k]), 64'd0);
    check("rej_done2", 64'(done[k]), 64'd0);
  endtask

  task automatic random_phase(input int k);
    int          n;
    longint      a;
    logic [63:0] bad;
    pool.delete();
    pool.push_back(0);
    pool.push_back(Depth - 1);
    for (int i = 0; i < 4; i++) pool.push_back(longint'($urandom_range(0, Depth - 1)));
    foreach (pool[i]) req(k, 1'b1, 64'(pool[i]), {$urandom, $urandom}, 8'hFF, 1'b0);
    for (int i = 0; i < 40; i++) begin
      n = $urandom_range(0, 9);
      a = pool[$urandom_range(0, pool.size() - 1)];
      if (n == 0) begin
        bad = ($urandom_range(0, 1) == 0) ? 64'(Depth + $urandom_range(0, 1000))
                                          : {1'b1, 31'($urandom), 32'(a)};
        rej(k, 1'b1, 1'b0, bad);
      end else if (n == 1) begin
        rej(k, 1'b1, 1'b1, 64'(a));
      end else if (n < 6) begin
        req(k, 1'b1, 64'(a), {$urandom, $urandom}, 8'($urandom), 1'b0);
      end else begin
        req(k, 1'b0, 64'(a), 64'h0, 8'h00, 1'b0);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; re[k] = 1'b0; we[k] = 1'b0;
      addr[k] = '0; wdata[k] = '0; be[k] = '0;
      err_exp[k] = 1'b0; rd_exp[k] = '0;
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      check("reset_busy", 64'(busy[k]), 64'd0);
      check("reset_done", 64'(done[k]), 64'd0);
      check("reset_err", 64'(err[k]), 64'd0);
      check("reset_rdata", rdata[k], 64'd0);
    end
    repeat (2) @(negedge clk);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;

    // LATENCY=1: full write/readback, then partial byte-enable write.
    req(0, 1'b1, 64'd5, 64'h1122334455667788, 8'hFF, 1'b0);
    req(0, 1'b0, 64'd5, 64'h0, 8'h00, 1'b0);
    check("s1_value", rdata[0], 64'h1122334455667788);
    req(0, 1'b1, 64'd5, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 1'b0);
    req(0, 1'b0, 64'd5, 64'h0, 8'h00, 1'b0);
    check("s2_value", rdata[0], 64'h11223344AAAAAAAA);
    req(0, 1'b1, 64'd5, 64'hFFFFFFFFFFFFFFFF, 8'h00, 1'b0);
    req(0, 1'b0, 64'd5, 64'h0, 8'h00, 1'b0);
    check("be_zero_value", rdata[0], 64'h11223344AAAAAAAA);

    // Rejections: both enables, out-of-range, and a high bit beyond the array index.
    rej(0, 1'b1, 1'b1, 64'd3);
    rej(0, 1'b1, 1'b0, 64'd16384);
    rej(0, 1'b0, 1'b1, 64'h8000_0000_0000_0005);
    req(0, 1'b0, 64'd5, 64'h0, 8'h00, 1'b0);
    check("s4_value", rdata[0], 64'h11223344AAAAAAAA);

    // LATENCY=4: read with write_en toggling during BUSY.
    req(1, 1'b1, 64'd7, 64'h0123456789ABCDEF, 8'hFF, 1'b0);
    req(1, 1'b0, 64'd7, 64'h0, 8'h00, 1'b1);
    check("s3_err", 64'(err[1]), 64'd0);
    req(1, 1'b0, 64'd7, 64'h0, 8'h00, 1'b0);
    check("s3_value", rdata[1], 64'h0123456789ABCDEF);

    // Reset two cycles into a write must abort it and clear all outputs.
    req(1, 1'b1, 64'd9, 64'h0, 8'hFF, 1'b0);
    rej(1, 1'b1, 1'b1, 64'd9);
    @(negedge clk);
    we[1] = 1'b1; addr[1] = 64'd9; wdata[1] = 64'hDEAD; be[1] = 8'hFF;
    @(posedge clk); #1;
    we[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n[1] = 1'b0;
    #1;
    err_exp[1] = 1'b0; rd_exp[1] = '0;
    check("s5_busy", 64'(busy[1]), 64'd0);
    check("s5_done", 64'(done[1]), 64'd0);
    check("s5_err", 64'(err[1]), 64'd0);
    check("s5_rdata", rdata[1], 64'd0);
    @(negedge clk);
    rst_n[1] = 1'b1;
    req(1, 1'b0, 64'd9, 64'h0, 8'h00, 1'b0);
    check("s5_no_commit", rdata[1], 64'h0);

    random_phase(0);
    random_phase(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
